io_flag_port: RTL

IO_FLAG_PORT -- requirements
Module: io_flag_port

---
 rtl/bc_io_pkg.sv | 22 ++
 rtl/io_flag_port_if.sv | 30 +++
 rtl/io_in_fifo.sv | 65 ++++++
 rtl/io_flag_port.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/bc_io_pkg.sv
// Shared definitions for the accumulator I/O port: default character width,
// output-side state encoding and pointer/count width helpers.
package bc_io_pkg;

   localparam int CHAR_W_DEF = 8;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } out_state_e;

   // Pointer width for a power-of-two buffer; never narrower than one bit.
   function automatic int ptr_w(input int depth);
      return (depth > 32'sd1) ? $clog2(depth) : 32'sd1;
   endfunction

   // Count width has one extra bit so that "full" is representable.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 32'sd1;
   endfunction

endpackage

// File: rtl/io_flag_port_if.sv
// Bundle of keyboard-side, printer-side and controller-side signals of the
// flag-driven I/O port; slave is the port itself, master is its environment.
interface io_flag_port_if #(
   parameter int CHAR_W = 8
) ();

   logic              dev_in_valid;
   logic [CHAR_W-1:0] dev_in_data;
   logic              dev_in_ready;
   logic              clr_fgi;
   logic [CHAR_W-1:0] inpr;
   logic              fgi;
   logic              ld_outr;
   logic [CHAR_W-1:0] ac_lo;
   logic              fgo;
   logic              dev_out_valid;
   logic [CHAR_W-1:0] dev_out_data;
   logic              dev_out_ready;

   modport slave (
      input  dev_in_valid, dev_in_data, clr_fgi, ld_outr, ac_lo, dev_out_ready,
      output dev_in_ready, inpr, fgi, fgo, dev_out_valid, dev_out_data
   );

   modport master (
      output dev_in_valid, dev_in_data, clr_fgi, ld_outr, ac_lo, dev_out_ready,
      input  dev_in_ready, inpr, fgi, fgo, dev_out_valid, dev_out_data
   );

endinterface

// File: rtl/io_in_fifo.sv
// Input character buffer sitting behind INPR: power-of-two ring with wrapping
// pointers; a write while full is taken only when a read happens on the same edge.
module io_in_fifo
   import bc_io_pkg::*;
#(
   parameter int DATA_W = CHAR_W_DEF,
   parameter int DEPTH  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [DATA_W-1:0]         wr_data,
   input  logic                      rd_en,
   output logic [DATA_W-1:0]         rd_data,
   output logic [cnt_w(DEPTH)-1:0]   count,
   output logic                      empty,
   output logic                      full
);

   localparam int PTR_W = ptr_w(DEPTH);
   localparam int CNT_W = cnt_w(DEPTH);

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [CNT_W-1:0]  count_r;
   logic              do_wr_s;
   logic              do_rd_s;

   assign empty   = (count_r == CNT_W'(0));
   assign full    = (count_r == CNT_W'(DEPTH));
   assign do_rd_s = rd_en && !empty;
   assign do_wr_s = wr_en && (!full || do_rd_s);
   assign rd_data = mem_r[rd_ptr_r];
   assign count   = count_r;

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= PTR_W'(0);
         rd_ptr_r <= PTR_W'(0);
         count_r  <= CNT_W'(0);
      end else begin
         if (do_wr_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (do_rd_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({do_wr_s, do_rd_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_wr_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

endmodule

// File: rtl/io_flag_port.sv
// Flag-handshake I/O port (FGI/INPR input side, FGO/OUTR output side).
// Optional printer-to-keyboard loopback is enabled by IO_FLAG_PORT_LOOPBACK_EN.
module io_flag_port
   import bc_io_pkg::*;
#(
   parameter int CHAR_W   = CHAR_W_DEF,
   parameter int IN_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
`ifdef IO_FLAG_PORT_LOOPBACK_EN
   input  logic          lb_mode,
`endif
   io_flag_port_if.slave bus
);

   localparam int CNT_W = cnt_w(IN_DEPTH);

   out_state_e        state_r;
   out_state_e        state_nxt_s;
   logic [CHAR_W-1:0] outr_r;
   logic              outr_ld_s;
   logic [CHAR_W-1:0] inpr_r;
   logic [CHAR_W-1:0] inpr_nxt_s;
   logic              fgi_r;
   logic              fgi_nxt_s;
   logic [CHAR_W-1:0] fifo_head_s;
   logic [CNT_W-1:0]  fifo_count_s;
   logic              fifo_empty_s;
   logic              fifo_full_s;
   logic              fifo_wr_s;
   logic              fifo_rd_s;
   logic              pop_req_s;
   logic              space_s;
   logic              in_ready_s;
   logic              push_s;
   logic [CHAR_W-1:0] push_data_s;
   logic              direct_s;
   logic              lb_mode_s;
   logic              lb_push_s;

`ifdef IO_FLAG_PORT_LOOPBACK_EN
   assign lb_mode_s = lb_mode;
   assign lb_push_s = lb_mode && (state_r == SEND) && space_s;
`else
   assign lb_mode_s = 1'b0;
   assign lb_push_s = 1'b0;
`endif

   // A pop on the same edge frees a slot, so a full port can still accept.
   assign pop_req_s   = bus.clr_fgi && fgi_r;
   assign space_s     = !(fifo_full_s && fgi_r) || pop_req_s;
   assign in_ready_s  = !lb_mode_s && space_s;
   assign push_s      = lb_push_s || (bus.dev_in_valid && in_ready_s);
   assign push_data_s = lb_push_s ? outr_r : bus.dev_in_data;
   assign direct_s    = push_s && fifo_empty_s && (!fgi_r || pop_req_s);
   assign fifo_wr_s   = push_s && !direct_s;
   assign fifo_rd_s   = pop_req_s && !fifo_empty_s;

   io_in_fifo #(
      .DATA_W (CHAR_W),
      .DEPTH  (IN_DEPTH)
   ) u_in_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (fifo_wr_s),
      .wr_data (push_data_s),
      .rd_en   (fifo_rd_s),
      .rd_data (fifo_head_s),
      .count   (fifo_count_s),
      .empty   (fifo_empty_s),
      .full    (fifo_full_s)
   );

   // Next INPR/FGI from direct loads, buffer pops and controller clears.
   always_comb begin
      inpr_nxt_s = inpr_r;
      fgi_nxt_s  = fgi_r;
      if (direct_s) begin
         inpr_nxt_s = push_data_s;
         fgi_nxt_s  = 1'b1;
      end else if (fifo_rd_s) begin
         inpr_nxt_s = fifo_head_s;
         fgi_nxt_s  = 1'b1;
      end else if (pop_req_s) begin
         fgi_nxt_s  = 1'b0;
      end else begin
         fgi_nxt_s  = fgi_r;
      end
   end

   // Input-side registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inpr_r <= {CHAR_W{1'b0}};
         fgi_r  <= 1'b0;
      end else begin
         inpr_r <= inpr_nxt_s;
         fgi_r  <= fgi_nxt_s;
      end
   end

   // Output FSM next state; loopback drains SEND into the input path instead.
   always_comb begin
      state_nxt_s = state_r;
      outr_ld_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.ld_outr) begin
               state_nxt_s = SEND;
               outr_ld_s   = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SEND: begin
            if (lb_mode_s) begin
               state_nxt_s = space_s ? IDLE : SEND;
            end else if (bus.dev_out_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = SEND;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Output FSM state and OUTR registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         outr_r  <= {CHAR_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         if (outr_ld_s) begin
            outr_r <= bus.ac_lo;
         end
      end
   end

   assign bus.dev_in_ready  = in_ready_s;
   assign bus.inpr          = inpr_r;
   assign bus.fgi           = fgi_r;
   assign bus.fgo           = (state_r == IDLE);
   assign bus.dev_out_valid = (state_r == SEND) && !lb_mode_s;
   assign bus.dev_out_data  = outr_r;

endmodule
